// File: rtl/config_loader.sv
// Streams (address, data) word pairs from a valid/ready input onto the shared tile config bus.
// Optional build macro CONFIG_LOADER_CHECKSUM_EN adds a trailing XOR checksum word check.
//
// state    | meaning
// IDLE     | waiting for start; bus null
// GET_ADDR | accepting an address word (or END_MARKER)
// GET_DATA | accepting the data word for the latched address
// WRITE    | driving addr/data onto the bus for HOLD_CYCLES cycles
// GET_SUM  | accepting the checksum word (checksum build only)
// DONE     | bitstream complete; waiting for a new start
module config_loader #(
  parameter int unsigned HOLD_CYCLES = 1,
  parameter logic [31:0] END_MARKER  = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] config_addr,
  output logic [31:0] config_data,
  output logic        config_busy,
  output logic        config_done,
  output logic        config_error,
  output logic [15:0] write_count
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_ADDR = 3'd1,
    GET_DATA = 3'd2,
    WRITE    = 3'd3,
    GET_SUM  = 3'd4,
    DONE     = 3'd5
  } state_t;

  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

  state_t      state, state_nxt;
  logic [31:0] addr_q, data_q;
  logic [3:0]  hold_cnt;
  logic        accept;
  logic        clr, ld_addr, ld_data, sum_chk;

  assign accept = in_valid & in_ready;

  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    ld_addr   = 1'b0;
    ld_data   = 1'b0;
    sum_chk   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          clr       = 1'b1;
          state_nxt = GET_ADDR;
        end
      end
      GET_ADDR: begin
        if (accept) begin
          if (in_data == END_MARKER) begin
`ifdef CONFIG_LOADER_CHECKSUM_EN
            state_nxt = GET_SUM;
`else
            state_nxt = DONE;
`endif
          end else begin
            ld_addr   = 1'b1;
            state_nxt = GET_DATA;
          end
        end
      end
      GET_DATA: begin
        if (accept) begin
          ld_data   = 1'b1;
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        if (hold_cnt == 4'd0) state_nxt = GET_ADDR;
      end
      GET_SUM: begin
        if (accept) begin
          sum_chk   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (start) begin
          clr       = 1'b1;
          state_nxt = GET_ADDR;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // in_ready is registered from the next state so it never sees in_valid
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      in_ready    <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      hold_cnt    <= '0;
      write_count <= '0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt == GET_ADDR) || (state_nxt == GET_DATA) ||
                  (state_nxt == GET_SUM);
      if (ld_addr) addr_q <= in_data;
      if (ld_data) data_q <= in_data;
      if (ld_data)
        hold_cnt <= HOLD_LOAD;
      else if ((state == WRITE) && (hold_cnt != 4'd0))
        hold_cnt <= hold_cnt - 4'd1;
      if (clr)
        write_count <= '0;
      else if (ld_data && (write_count != 16'hFFFF))
        write_count <= write_count + 16'd1;
    end
  end

`ifdef CONFIG_LOADER_CHECKSUM_EN
  logic [31:0] cksum_q;
  logic        error_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cksum_q <= '0;
      error_q <= 1'b0;
    end else begin
      if (clr)
        cksum_q <= '0;
      else if (ld_addr || ld_data)
        cksum_q <= cksum_q ^ in_data;
      if (clr)
        error_q <= 1'b0;
      else if (sum_chk && (in_data != cksum_q))
        error_q <= 1'b1;
    end
  end

  assign config_error = error_q;
`else
  assign config_error = 1'b0;
`endif

  // Bus decodes straight from state so an async reset nulls it immediately
  assign config_addr = (state == WRITE) ? addr_q : 32'h0;
  assign config_data = (state == WRITE) ? data_q : 32'h0;
  assign config_busy = (state != IDLE) && (state != DONE);
  assign config_done = (state == DONE);

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader: one HOLD_CYCLES=1 and one HOLD_CYCLES=3 instance.
// Build with CONFIG_LOADER_CHECKSUM_EN defined to exercise the checksum word.
module tb_config_loader;

  localparam logic [31:0] END_W = 32'hFFFF_FFFF;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    int          c;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset, start, in_valid;
  logic [31:0] in_data;

  logic        r1, busy1, done1, err1;
  logic [31:0] a1, d1;
  logic [15:0] wc1;
  logic        r3, busy3, done3, err3;
  logic [31:0] a3, d3;
  logic [15:0] wc3;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          viol3 = 0;
  logic [31:0] tb_sum = '0;
  wr_t         log1[$];
  wr_t         log3[$];

  always #5 clk = ~clk;

  config_loader #(.HOLD_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(r1), .config_addr(a1), .config_data(d1), .config_busy(busy1),
    .config_done(done1), .config_error(err1), .write_count(wc1)
  );

  config_loader #(.HOLD_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(r3), .config_addr(a3), .config_data(d3), .config_busy(busy3),
    .config_done(done3), .config_error(err3), .write_count(wc3)
  );

  always @(posedge clk) cyc++;

  // Log every cycle the bus carries a write, sampled mid-cycle
  always @(negedge clk) begin
    if (reset) begin
      if (a1 != 32'h0 || d1 != 32'h0) log1.push_back('{a1, d1, cyc});
      if (a3 != 32'h0 || d3 != 32'h0) begin
        log3.push_back('{a3, d3, cyc});
        if (r3) viol3++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input bit h3, input logic [31:0] w, input int gap);
    bit got;
    got = 1'b0;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    for (int n = 0; n < 40 && !got; n++) begin
      logic rdy;
      rdy = h3 ? r3 : r1;
      @(negedge clk);
      got = rdy;
    end
    in_valid = 1'b0;
    check("handshake", {31'b0, got}, 32'h1);
  endtask

  task automatic pair(input bit h3, input logic [31:0] a, input logic [31:0] d, input int gap);
    send(h3, a, gap);
    send(h3, d, gap);
    tb_sum = tb_sum ^ a ^ d;
  endtask

  task automatic finish(input bit h3, input int gap);
    send(h3, END_W, gap);
`ifdef CONFIG_LOADER_CHECKSUM_EN
    send(h3, tb_sum, gap);
`endif
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    log1.delete();
    log3.delete();
    viol3  = 0;
    tb_sum = '0;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    // Test 1: reset with in_valid high, then idle with no start
    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'hAAAA_5555;
    @(negedge clk);
    check("rst_ready", {31'b0, r1}, 32'h0);
    check("rst_addr", a1, 32'h0);
    check("rst_data", d1, 32'h0);
    check("rst_busy", {31'b0, busy1}, 32'h0);
    check("rst_done", {31'b0, done1}, 32'h0);
    check("rst_err", {31'b0, err1}, 32'h0);
    check("rst_wc", {16'b0, wc1}, 32'h0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_ready", {31'b0, r1}, 32'h0);
    check("idle_busy", {31'b0, busy1}, 32'h0);

    // Test 2: single pair, HOLD_CYCLES=1
    do_reset();
    pulse_start();
    check("t2_busy", {31'b0, busy1}, 32'h1);
    pair(0, 32'h0007_0003, 32'h0000_0005, 0);
    finish(0, 0);
    check("t2_done", {31'b0, done1}, 32'h1);
    check("t2_busy_off", {31'b0, busy1}, 32'h0);
    check("t2_wc", {16'b0, wc1}, 32'h1);
    check("t2_err", {31'b0, err1}, 32'h0);
    check("t2_nwr", log1.size(), 32'd1);
    if (log1.size() == 1) begin
      check("t2_addr", log1[0].a, 32'h0007_0003);
      check("t2_data", log1[0].d, 32'h0000_0005);
    end

    // Test 3: HOLD_CYCLES=3, two pairs back to back
    do_reset();
    pulse_start();
    pair(1, 32'h0001_0002, 32'h0000_00A1, 0);
    pair(1, 32'h0003_0004, 32'h0000_00B2, 0);
    finish(1, 0);
    check("t3_done", {31'b0, done3}, 32'h1);
    check("t3_wc", {16'b0, wc3}, 32'h2);
    check("t3_nwr", log3.size(), 32'd6);
    check("t3_ready_in_hold", viol3, 32'd0);
    if (log3.size() == 6) begin
      for (int i = 0; i < 3; i++) begin
        check("t3_a_addr", log3[i].a, 32'h0001_0002);
        check("t3_a_data", log3[i].d, 32'h0000_00A1);
        check("t3_b_addr", log3[i+3].a, 32'h0003_0004);
        check("t3_b_data", log3[i+3].d, 32'h0000_00B2);
      end
      check("t3_a_span", log3[2].c - log3[0].c, 32'd2);
      check("t3_b_start", log3[3].c - log3[0].c, 32'd5);
    end

    // Test 4: 2-cycle valid gaps, bus stays null while waiting
    do_reset();
    pulse_start();
    send(0, 32'h0007_0003, 2);
    repeat (2) @(negedge clk);
    check("t4_wait_addr", a1, 32'h0);
    check("t4_wait_busy", {31'b0, busy1}, 32'h1);
    send(0, 32'h0000_0005, 0);
    tb_sum = 32'h0007_0003 ^ 32'h0000_0005;
    finish(0, 2);
    check("t4_done", {31'b0, done1}, 32'h1);
    check("t4_wc", {16'b0, wc1}, 32'h1);
    check("t4_nwr", log1.size(), 32'd1);
    if (log1.size() == 1) begin
      check("t4_addr", log1[0].a, 32'h0007_0003);
      check("t4_data", log1[0].d, 32'h0000_0005);
    end

    // Address 0 no-op, start while busy, start coinciding with the final handshake
    do_reset();
    pulse_start();
    pair(0, 32'h0000_0000, 32'h0000_0009, 0);
    pulse_start();
    pair(0, 32'h0001_0001, 32'h0000_0002, 0);
    @(negedge clk);
`ifdef CONFIG_LOADER_CHECKSUM_EN
    send(0, END_W, 0);
    start = 1'b1;
    send(0, tb_sum, 0);
`else
    start = 1'b1;
    send(0, END_W, 0);
`endif
    start = 1'b0;
    check("b_done", {31'b0, done1}, 32'h1);
    check("b_wc", {16'b0, wc1}, 32'h2);
    check("b_nwr", log1.size(), 32'd2);
    if (log1.size() == 2) begin
      check("b_zero_addr", log1[0].a, 32'h0);
      check("b_zero_data", log1[0].d, 32'h0000_0009);
      check("b_w2_addr", log1[1].a, 32'h0001_0001);
    end
    repeat (2) @(negedge clk);
    check("b_start_lost_done", {31'b0, done1}, 32'h1);
    check("b_start_lost_busy", {31'b0, busy1}, 32'h0);

    // Test 5: async reset in the middle of a 3-cycle write
    do_reset();
    pulse_start();
    send(1, 32'h0005_0006, 0);
    send(1, 32'h0000_00C3, 0);
    check("t5_writing", a3, 32'h0005_0006);
    reset = 1'b0;
    #1;
    check("t5_addr_now", a3, 32'h0);
    check("t5_data_now", d3, 32'h0);
    check("t5_wc_now", {16'b0, wc3}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t5_busy", {31'b0, busy3}, 32'h0);
    check("t5_done", {31'b0, done3}, 32'h0);
    check("t5_ready", {31'b0, r3}, 32'h0);
    check("t5_wc", {16'b0, wc3}, 32'h0);

`ifdef CONFIG_LOADER_CHECKSUM_EN
    // Test 6: good checksum, then bad checksum
    do_reset();
    pulse_start();
    send(0, 32'h0004_0001, 0);
    send(0, 32'h0000_0002, 0);
    send(0, END_W, 0);
    check("t6_wait_sum", {31'b0, done1}, 32'h0);
    send(0, 32'h0004_0003, 0);
    check("t6_ok_err", {31'b0, err1}, 32'h0);
    check("t6_ok_done", {31'b0, done1}, 32'h1);
    pulse_start();
    send(0, 32'h0004_0001, 0);
    send(0, 32'h0000_0002, 0);
    send(0, END_W, 0);
    send(0, 32'h0000_0000, 0);
    check("t6_bad_err", {31'b0, err1}, 32'h1);
    check("t6_bad_done", {31'b0, done1}, 32'h1);
    pulse_start();
    check("t6_err_clr", {31'b0, err1}, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
